// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the mem_responder cache-refill responder.
// Holds the FSM state encoding and parameter-derived width helpers.
package mem_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        BEAT,
        GAP,
        DONE
    } state_e;

    localparam int unsigned BYTE_OFFSET = 2;

    function automatic int unsigned line_words(input int unsigned word_offset);
        return 32'd1 << word_offset;
    endfunction

    // Counter must hold the larger of the two reload values.
    function automatic int unsigned cnt_width(input int unsigned first_lat,
                                              input int unsigned beat_gap);
        int unsigned m;
        m = (first_lat > beat_gap) ? first_lat : beat_gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for mem_responder: combinational read, synchronous backdoor write.
// Contents are intentionally left unreset.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_ADR_BITS = 10
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [MEM_ADR_BITS-1:0] wadr_i,
    input  logic [DATA_WIDTH-1:0]   wdat_i,
    input  logic [MEM_ADR_BITS-1:0] radr_i,
    output logic [DATA_WIDTH-1:0]   rdat_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**MEM_ADR_BITS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wadr_i] <= wdat_i;
        end
    end

    assign rdat_o = mem_q[radr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder answering cache line refills with a timed burst of acks.
// Define MEM_RESP_CRITICAL_FIRST_EN to return the requested word first (wrapping in the line).
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WORD_OFFSET  = 2,
    parameter int unsigned MEM_ADR_BITS = 10,
    parameter int unsigned FIRST_LAT    = 5,
    parameter int unsigned BEAT_GAP     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_cc2mem,
    input  logic [ADR_WIDTH-1:0]    adr_cc2mem,
    output logic                    ack_mem2cc,
    output logic [DATA_WIDTH-1:0]   dat_mem2cc,
    output logic [WORD_OFFSET-1:0]  word_mem2cc,
    output logic                    busy,
    input  logic                    ld_en,
    input  logic [MEM_ADR_BITS-1:0] ld_adr,
    input  logic [DATA_WIDTH-1:0]   ld_dat
);

    localparam int unsigned LINE_WORDS = line_words(WORD_OFFSET);
    localparam int unsigned CNT_W      = cnt_width(FIRST_LAT, BEAT_GAP);
    localparam int unsigned BASE_W     = MEM_ADR_BITS - WORD_OFFSET;
    localparam int unsigned FL_M1      = FIRST_LAT - 1;
    localparam int unsigned GAP_M1     = (BEAT_GAP > 0) ? BEAT_GAP - 1 : 0;

    localparam logic [CNT_W-1:0]   FL_LOAD  = FL_M1[CNT_W-1:0];
    localparam logic [CNT_W-1:0]   GAP_LOAD = GAP_M1[CNT_W-1:0];
    localparam logic [WORD_OFFSET:0] LW_C   = LINE_WORDS[WORD_OFFSET:0];

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [BASE_W-1:0]       base_q;
    logic [WORD_OFFSET-1:0]  word_q;
    logic [WORD_OFFSET:0]    beats_q;
    logic                    ack_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [WORD_OFFSET-1:0]  wout_q;
    logic                    busy_q;

    logic [MEM_ADR_BITS-1:0] req_idx;
    logic [WORD_OFFSET-1:0]  start_word;
    logic [MEM_ADR_BITS-1:0] rd_adr;
    logic [DATA_WIDTH-1:0]   rd_dat;
    logic                    last_beat;
    logic                    issue;
    logic                    unused_adr;

    assign req_idx = adr_cc2mem[MEM_ADR_BITS+1:BYTE_OFFSET];

`ifdef MEM_RESP_CRITICAL_FIRST_EN
    assign start_word = req_idx[WORD_OFFSET-1:0];
`else
    assign start_word = '0;
`endif

    assign unused_adr = ^{adr_cc2mem[ADR_WIDTH-1:MEM_ADR_BITS+2],
                          adr_cc2mem[BYTE_OFFSET-1:0],
                          req_idx[WORD_OFFSET-1:0]};

    assign rd_adr    = {base_q, word_q};
    assign last_beat = (beats_q == LW_C);

    mem_resp_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MEM_ADR_BITS(MEM_ADR_BITS)
    ) u_array (
        .clk   (clk),
        .we_i  (ld_en),
        .wadr_i(ld_adr),
        .wdat_i(ld_dat),
        .radr_i(rd_adr),
        .rdat_o(rd_dat)
    );

    // A beat is launched on the edge that leaves a countdown at zero, or
    // directly from BEAT when beats are back-to-back.
    always_comb begin
        issue = 1'b0;
        if (req_cc2mem) begin
            unique case (state_q)
                WAIT, GAP: issue = (cnt_q == '0);
                BEAT:      issue = !last_beat && (BEAT_GAP == 0);
                default:   issue = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            word_q  <= '0;
            beats_q <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            wout_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_cc2mem) begin
                        state_q <= WAIT;
                        cnt_q   <= FL_LOAD;
                        base_q  <= req_idx[MEM_ADR_BITS-1:WORD_OFFSET];
                        word_q  <= start_word;
                        beats_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT, GAP: begin
                    if (!req_cc2mem) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                BEAT: begin
                    if (!req_cc2mem) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (last_beat) begin
                        state_q <= DONE;
                    end else if (BEAT_GAP > 0) begin
                        state_q <= GAP;
                        cnt_q   <= GAP_LOAD;
                    end
                end
                DONE: begin
                    if (!req_cc2mem) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (issue) begin
                state_q <= BEAT;
                ack_q   <= 1'b1;
                dat_q   <= rd_dat;
                wout_q  <= word_q;
                word_q  <= word_q + 1'b1;
                beats_q <= beats_q + 1'b1;
            end
        end
    end

    assign ack_mem2cc  = ack_q;
    assign dat_mem2cc  = dat_q;
    assign word_mem2cc = wout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table of line requests, scoreboard of expected beats.
// Follows MEM_RESP_CRITICAL_FIRST_EN for the expected beat order.
module tb_mem_responder;

`ifdef MEM_RESP_CRITICAL_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef struct {
        logic [31:0] dat;
        logic [1:0]  word;
        int          cyc;
    } exp_t;

    typedef struct {
        int          sel;
        logic [31:0] adr;
        int          beats;
        int          ldk;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [2];
    logic [31:0] adr    [2];
    logic        ld_en  [2];
    logic [9:0]  ld_adr [2];
    logic [31:0] ld_dat [2];
    logic        ack    [2];
    logic [31:0] dat    [2];
    logic [1:0]  wrd    [2];
    logic        busy   [2];

    exp_t        q [2][$];
    logic [31:0] mem_m [2][1024];
    logic [31:0] last_dat [2];
    logic [1:0]  last_wrd [2];
    int          ack_cnt [2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(
        .ADR_WIDTH(32), .DATA_WIDTH(32), .WORD_OFFSET(2), .MEM_ADR_BITS(10),
        .FIRST_LAT(5), .BEAT_GAP(3)
    ) u_a (
        .clk(clk), .rst(rst), .req_cc2mem(req[0]), .adr_cc2mem(adr[0]),
        .ack_mem2cc(ack[0]), .dat_mem2cc(dat[0]), .word_mem2cc(wrd[0]), .busy(busy[0]),
        .ld_en(ld_en[0]), .ld_adr(ld_adr[0]), .ld_dat(ld_dat[0])
    );

    mem_responder #(
        .ADR_WIDTH(32), .DATA_WIDTH(32), .WORD_OFFSET(2), .MEM_ADR_BITS(10),
        .FIRST_LAT(1), .BEAT_GAP(0)
    ) u_b (
        .clk(clk), .rst(rst), .req_cc2mem(req[1]), .adr_cc2mem(adr[1]),
        .ack_mem2cc(ack[1]), .dat_mem2cc(dat[1]), .word_mem2cc(wrd[1]), .busy(busy[1]),
        .ld_en(ld_en[1]), .ld_adr(ld_adr[1]), .ld_dat(ld_dat[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_step(input int s);
        exp_t e;
        if (rst) begin
            last_dat[s] = '0;
            last_wrd[s] = '0;
        end else if (ack[s]) begin
            ack_cnt[s]++;
            if (q[s].size() == 0) begin
                chk($sformatf("unexpected_ack%0d", s), 32'(ack[s]), 32'd0);
            end else begin
                e = q[s].pop_front();
                chk($sformatf("beat_dat%0d", s), dat[s], e.dat);
                chk($sformatf("beat_word%0d", s), 32'(wrd[s]), 32'(e.word));
                chk($sformatf("beat_cycle%0d", s), 32'(cyc), 32'(e.cyc));
                last_dat[s] = e.dat;
                last_wrd[s] = e.word;
            end
        end else if (busy[s]) begin
            chk($sformatf("hold_dat%0d", s), dat[s], last_dat[s]);
            chk($sformatf("hold_word%0d", s), 32'(wrd[s]), 32'(last_wrd[s]));
        end
    endtask

    always @(negedge clk) mon_step(0);
    always @(negedge clk) mon_step(1);

    // Issue one request at the current negedge+1 point; beats<4 drops req after that many acks.
    task automatic run_req(input int s, input logic [31:0] a, input int beats, input int ldk);
        int          fl, g, n, start_acks, ld_cyc;
        logic [9:0]  idx, ld_target;
        logic [1:0]  start, w;
        logic [31:0] ld_val;
        bit          done;
        exp_t        e;

        fl = (s == 0) ? 5 : 1;
        g  = (s == 0) ? 3 : 0;
        idx   = a[11:2];
        start = CWF ? idx[1:0] : 2'd0;
        n     = cyc + 1;
        start_acks = ack_cnt[s];
        ld_cyc    = -10;
        ld_target = '0;
        ld_val    = $urandom;
        req[s] = 1'b1;
        adr[s] = a;
        for (int k = 0; k < beats; k++) begin
            w = start + 2'(k);
            e.dat  = mem_m[s][{idx[9:2], w}];
            e.word = w;
            e.cyc  = n + fl + k * (g + 1);
            q[s].push_back(e);
        end
        if (ldk >= 0) begin
            w = start + 2'(ldk);
            ld_target = {idx[9:2], w};
            ld_cyc    = n + fl + ldk * (g + 1);
        end

        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            #1;
            if (t == 0) adr[s] = $urandom;
            if (ld_en[s]) begin
                ld_en[s] = 1'b0;
                mem_m[s][ld_adr[s]] = ld_dat[s];
            end
            if (ldk >= 0 && cyc == ld_cyc - 1) begin
                ld_en[s]  = 1'b1;
                ld_adr[s] = ld_target;
                ld_dat[s] = ld_val;
            end
            if (ack_cnt[s] - start_acks >= beats) done = 1'b1;
        end
        chk($sformatf("burst_complete%0d", s), 32'(done), 32'd1);
        if (!done) q[s].delete();

        if (beats < 4) begin
            req[s] = 1'b0;
            @(negedge clk);
            #1;
            chk($sformatf("abort_busy%0d", s), 32'(busy[s]), 32'd0);
            repeat (12) @(negedge clk);
            #1;
            chk($sformatf("abort_queue%0d", s), 32'(q[s].size()), 32'd0);
        end else begin
            repeat (10) @(negedge clk);
            #1;
            chk($sformatf("done_busy%0d", s), 32'(busy[s]), 32'd1);
            chk($sformatf("done_queue%0d", s), 32'(q[s].size()), 32'd0);
            req[s] = 1'b0;
            @(negedge clk);
            #1;
            chk($sformatf("release_busy%0d", s), 32'(busy[s]), 32'd0);
        end
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = '{0, 32'h0000_0100, 4, -1};
        tbl[1] = '{0, 32'h0000_0108, 4, -1};
        tbl[2] = '{0, 32'h0000_0104, 2, -1};
        tbl[3] = '{0, 32'h0000_0200, 4, -1};
        tbl[4] = '{0, 32'hABCD_0FF4, 4, -1};
        tbl[5] = '{0, 32'h0000_010C, 4,  1};
        tbl[6] = '{0, 32'h0000_010C, 4, -1};
        tbl[7] = '{1, 32'h0000_0100, 4, -1};
        tbl[8] = '{1, 32'h0000_0108, 2, -1};
        tbl[9] = '{1, 32'h0000_0204, 4, -1};

        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; adr[s] = '0; ld_en[s] = 1'b0; ld_adr[s] = '0; ld_dat[s] = '0;
            ack_cnt[s] = 0; last_dat[s] = '0; last_wrd[s] = '0;
        end

        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset_ack%0d", s), 32'(ack[s]), 32'd0);
            chk($sformatf("reset_dat%0d", s), dat[s], 32'd0);
            chk($sformatf("reset_word%0d", s), 32'(wrd[s]), 32'd0);
            chk($sformatf("reset_busy%0d", s), 32'(busy[s]), 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 1024; i++) begin
            logic [31:0] v;
            v = (i >= 32'h40 && i < 32'h44) ? 32'hA0 + 32'(i - 32'h40)
                                            : 32'hC000_0000 | (32'(i) * 32'h0001_0003);
            @(negedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                ld_en[s] = 1'b1; ld_adr[s] = 10'(i); ld_dat[s] = v;
                mem_m[s][i] = v;
            end
        end
        @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) ld_en[s] = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_req(tbl[i].sel, tbl[i].adr, tbl[i].beats, tbl[i].ldk);
        end

        // Reset while waiting for the first beat, with req held through release.
        req[0] = 1'b1;
        adr[0] = 32'h0000_0108;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_reset_busy", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_reset_ack", 32'(ack[0]), 32'd0);
        chk("mid_reset_dat", dat[0], 32'd0);
        chk("mid_reset_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        run_req(0, 32'h0000_0108, 4, -1);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the 4-way cache controller's refill interface. It answers a cache line request on `req_cc2mem`/`adr_cc2mem` with a burst of `LINE_WORDS` one-cycle `ack_mem2cc` pulses, each carrying one 32-bit word on `dat_mem2cc` from an internal word array. It sits where main memory sits in simulation and lets the cache be exercised without hand-timed ack stimulus. A backdoor load port preloads memory contents.

## Interface
- `ADR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: word width.
- `WORD_OFFSET`, 2: log2 of words per line; `LINE_WORDS` = 2**`WORD_OFFSET`.
- `MEM_ADR_BITS`, 10: log2 of array depth in words.
- `FIRST_LAT`, 5: cycles from request acceptance to first ack; minimum 1.
- `BEAT_GAP`, 3: ack-low cycles between beats; 0 gives back-to-back acks.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_cc2mem` in 1: line request, held high by the cache for the whole refill.
- `adr_cc2mem` in `ADR_WIDTH`: byte address of the requested word.
- `ack_mem2cc` out 1: one-cycle beat strobe.
- `dat_mem2cc` out `DATA_WIDTH`: beat data, valid while ack is high.
- `word_mem2cc` out `WORD_OFFSET`: word index within the line for the current beat.
- `busy` out 1: high from request acceptance until return to IDLE.
- `ld_en` in 1: backdoor write enable.
- `ld_adr` in `MEM_ADR_BITS`: backdoor word address.
- `ld_dat` in `DATA_WIDTH`: backdoor write data.

## Operation
- Array index is `adr[MEM_ADR_BITS+1:2]`; byte bits [1:0] are ignored.
- The line base clears the low `WORD_OFFSET` bits of the word index.
- States and transitions:
  - IDLE: `req_cc2mem` high at an edge → latch the line base and start word → WAIT, counter loaded with `FIRST_LAT`-1.
  - WAIT: counter reaches 0 → BEAT.
  - BEAT: ack is high for exactly one cycle. After the last beat → DONE. Otherwise → GAP if `BEAT_GAP`>0, else BEAT again.
  - GAP: count `BEAT_GAP` cycles → BEAT.
  - DONE: wait for `req_cc2mem` low → IDLE. A request held high across the end of a burst is never re-served.
- `req_cc2mem` low in WAIT, GAP or BEAT aborts the burst: → IDLE at the next edge, and no further acks.
- Address changes while busy are ignored; only the address latched in IDLE is used.
- Beat data is read from the array at the edge that raises ack and is registered.
- `ld_en` is accepted in any state. If it hits the word read on the same edge, the beat returns the old value.
- `dat_mem2cc` and `word_mem2cc` hold the last beat's value between beats.
- Reset values: `ack_mem2cc`=0, `dat_mem2cc`=0, `word_mem2cc`=0, `busy`=0, state IDLE.
- Array contents are not reset.
- Reset mid-burst clears the state immediately and asynchronously; acks stop in the same cycle.

## Timing
- Request sampled at edge N.
- Beat k (k = 0…`LINE_WORDS`-1) has ack high during the cycle after edge N+`FIRST_LAT`+k·(`BEAT_GAP`+1).
- Default timing: first ack 5 cycles after acceptance, then a pulse every 4 cycles; 4 beats in 17 cycles.
- `busy` rises at edge N and falls at the edge after `req_cc2mem` is sampled low in DONE.
- Minimum re-request spacing: one IDLE cycle.

## Configuration
- `MEM_RESP_CRITICAL_FIRST_EN` defined: critical word first.
  - Beat 0 is the requested word; the index increments modulo `LINE_WORDS` (wrap-around within the line).
- Not defined: beats are always issued in order word 0…`LINE_WORDS`-1 regardless of the address offset.
- In both modes `word_mem2cc` reports the actual word index.

## Structure
- Package `mem_resp_pkg` holds:
  - the state enum (IDLE, WAIT, BEAT, GAP, DONE);
  - `LINE_WORDS` derivation;
  - counter width `$clog2(max(FIRST_LAT,BEAT_GAP)+1)`.
- Sub-module `mem_resp_array`: word storage with one combinational read port and one synchronous write port (the backdoor load).
- FSM, counters and beat index live in the top module.

## Test plan
- Preload words 0x40..0x43 with 0xA0..0xA3; request address 0x100; default parameters.
  - Expect 4 single-cycle acks, the first 5 cycles after acceptance, spaced 4 cycles apart.
  - Data 0xA0, 0xA1, 0xA2, 0xA3; `word_mem2cc` 0..3.
- Same preload, request 0x108 (word 2).
  - With the macro: order 0xA2, 0xA3, 0xA0, 0xA1.
  - Without the macro: 0xA0..0xA3.
- `BEAT_GAP`=0, `FIRST_LAT`=1: acks on 4 consecutive cycles starting 1 cycle after acceptance.
- Drop `req_cc2mem` after the second ack: no further acks; `busy` low next cycle; a new request to 0x200 is served normally.
- Assert `rst` during the WAIT state: ack, dat and busy go to 0 immediately. After `req_cc2mem` is held high through reset release, the next edge accepts a fresh burst.
- Hold `req_cc2mem` high 10 cycles past the last beat: no second burst. Deassert for 1 cycle and reassert: a new burst starts.
